div_sequencer: RTL

- Multi-cycle sequencer for 32-bit integer division.
- Drives one shared trial-subtract datapath, one iteration per clock, using restoring shift-subtract.
- Packs the 64-bit result as HI = remainder in [63:32] and LO = quotient in [31:0], ready for the HI/LO register pair.
- Sits beside the ALU; started by the control unit for DIV/DIVU and holds its result until the next start.

---
 rtl/div_sequencer.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/div_sequencer.sv
// ============================================================================
//  div_sequencer : restoring shift-subtract divider, one iteration per clock
//  Revision 1.0
// ============================================================================
`default_nettype none

module div_sequencer #(
   parameter int WIDTH = 32
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 start,
   input  logic                 signed_op,
   input  logic [WIDTH-1:0]     dividend,
   input  logic [WIDTH-1:0]     divisor,
   output logic                 busy,
   output logic                 done,
   output logic                 div_by_zero,
   output logic [2*WIDTH-1:0]   result
);

   localparam int CW = $clog2(WIDTH);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_PREP   = 3'd1;
   localparam logic [2:0] S_ITER   = 3'd2;
   localparam logic [2:0] S_FIXUP  = 3'd3;
   localparam logic [2:0] S_FINISH = 3'd4;

   logic [2:0]           state_q, state_d;
   logic                 sgn_q, sgn_d;
   logic [WIDTH-1:0]     dvd_q, dvd_d;
   logic [WIDTH-1:0]     dvs_q, dvs_d;
   logic [WIDTH:0]       rem_q, rem_d;
   logic [WIDTH-1:0]     quo_q, quo_d;
   logic [WIDTH-1:0]     den_q, den_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic                 qneg_q, qneg_d;
   logic                 rneg_q, rneg_d;
   logic                 zero_q, zero_d;
   logic                 dbz_q, dbz_d;
   logic [2*WIDTH-1:0]   result_q, result_d;

   logic                 w_dvd_neg;
   logic                 w_dvs_neg;
   logic [WIDTH-1:0]     w_dvd_mag;
   logic [WIDTH-1:0]     w_dvs_mag;
   logic [WIDTH:0]       w_rem_shift;
   logic [WIDTH:0]       w_diff;
   logic [WIDTH-1:0]     w_quo_fix;
   logic [WIDTH-1:0]     w_rem_fix;

   // Magnitudes are unsigned, so the most negative value maps to 2^(WIDTH-1)
   assign w_dvd_neg   = sgn_q & dvd_q[WIDTH-1];
   assign w_dvs_neg   = sgn_q & dvs_q[WIDTH-1];
   assign w_dvd_mag   = w_dvd_neg ? (~dvd_q + 1'b1) : dvd_q;
   assign w_dvs_mag   = w_dvs_neg ? (~dvs_q + 1'b1) : dvs_q;

   assign w_rem_shift = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
   assign w_diff      = w_rem_shift - {1'b0, den_q};

   assign w_quo_fix   = qneg_q ? (~quo_q + 1'b1) : quo_q;
   assign w_rem_fix   = rneg_q ? (~rem_q[WIDTH-1:0] + 1'b1) : rem_q[WIDTH-1:0];

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (start) state_d = S_PREP;
         S_PREP:   state_d = (dvs_q == '0) ? S_FIXUP : S_ITER;
         S_ITER:   if (cnt_q == '0) state_d = S_FIXUP;
         S_FIXUP:  state_d = S_FINISH;
         S_FINISH: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy = (state_q != S_IDLE);
      done = (state_q == S_FINISH);
   end

   always_comb begin
      sgn_d    = sgn_q;
      dvd_d    = dvd_q;
      dvs_d    = dvs_q;
      rem_d    = rem_q;
      quo_d    = quo_q;
      den_d    = den_q;
      cnt_d    = cnt_q;
      qneg_d   = qneg_q;
      rneg_d   = rneg_q;
      zero_d   = zero_q;
      dbz_d    = dbz_q;
      result_d = result_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               sgn_d = signed_op;
               dvd_d = dividend;
               dvs_d = divisor;
               dbz_d = 1'b0;
            end
         end
         S_PREP: begin
            // A zero divisor preloads the final pattern and reuses the fixup write
            if (dvs_q == '0) begin
               rem_d  = {1'b0, dvd_q};
               quo_d  = '1;
               qneg_d = 1'b0;
               rneg_d = 1'b0;
               zero_d = 1'b1;
            end else begin
               rem_d  = '0;
               quo_d  = w_dvd_mag;
               den_d  = w_dvs_mag;
               qneg_d = w_dvd_neg ^ w_dvs_neg;
               rneg_d = w_dvd_neg;
               zero_d = 1'b0;
               cnt_d  = CW'(WIDTH - 1);
            end
         end
         S_ITER: begin
            if (!w_diff[WIDTH]) begin
               rem_d = w_diff;
               quo_d = {quo_q[WIDTH-2:0], 1'b1};
            end else begin
               rem_d = w_rem_shift;
               quo_d = {quo_q[WIDTH-2:0], 1'b0};
            end
            cnt_d = cnt_q - 1'b1;
         end
         S_FIXUP: begin
            result_d = {w_rem_fix, w_quo_fix};
            dbz_d    = zero_q;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sgn_q    <= 1'b0;
         dvd_q    <= '0;
         dvs_q    <= '0;
         rem_q    <= '0;
         quo_q    <= '0;
         den_q    <= '0;
         cnt_q    <= '0;
         qneg_q   <= 1'b0;
         rneg_q   <= 1'b0;
         zero_q   <= 1'b0;
         dbz_q    <= 1'b0;
         result_q <= '0;
      end else begin
         sgn_q    <= sgn_d;
         dvd_q    <= dvd_d;
         dvs_q    <= dvs_d;
         rem_q    <= rem_d;
         quo_q    <= quo_d;
         den_q    <= den_d;
         cnt_q    <= cnt_d;
         qneg_q   <= qneg_d;
         rneg_q   <= rneg_d;
         zero_q   <= zero_d;
         dbz_q    <= dbz_d;
         result_q <= result_d;
      end
   end

   assign div_by_zero = dbz_q;
   assign result      = result_q;

endmodule

`default_nettype wire
